// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable word memory, byte-addressed PC, one
// in-flight synchronous read and a 2-entry output FIFO driving an
// AXI-stream style valid/ready interface toward decode.
module instr_fetch_unit #(
  parameter int                        ADDR_WIDTH = 16,
  parameter int                        DATA_WIDTH = 32,
  parameter int                        MEM_DEPTH  = 64,
  parameter logic [ADDR_WIDTH-1:0]     RESET_PC   = '0,
  localparam int                       IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  jmp_enable,
  input  logic [ADDR_WIDTH-1:0] jmp,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [ADDR_WIDTH-1:0] m_tpc,
  output logic [16:0]           ctrl_data_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  halted_o
);

  // Program end as a byte address; one bit wider so MEM_DEPTH*4 == 2^ADDR_WIDTH fits.
  localparam logic [ADDR_WIDTH:0] PROG_END = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);

  // The PC adder never wraps only if the whole program fits the address space;
  // the control-field extraction needs at least a 32-bit word.
  if (MEM_DEPTH * 4 > 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("instr_fetch_unit: MEM_DEPTH*4 must not exceed 2^ADDR_WIDTH");
  end
  if (DATA_WIDTH < 32) begin : g_bad_width
    $error("instr_fetch_unit: DATA_WIDTH must be at least 32");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [ADDR_WIDTH-1:0] fifo_pc   [2];
  logic [1:0]            count;

  logic       pc_end;
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;
  logic [IDX_W-1:0] rd_idx;

  assign pc_end = ({1'b0, pc} >= PROG_END);
  assign pop    = m_tvalid & m_tready;
  // Occupancy after this cycle's pop; pop implies count >= 1, so no underflow.
  assign occ    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue  = !rst && !jmp_enable && !pc_end && (occ < 3'd2);
  // The read issued last cycle always completes now; a redirect drops it.
  assign push   = inflight && !jmp_enable;
  assign rd_idx = pc[IDX_W+1:2];

  // Memory: independent write port, read-first synchronous read, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (issue) rd_data <= mem[rd_idx];
  end

  // PC and in-flight slot: redirect overrides issue, reset overrides both.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (jmp_enable) begin
      // Masking keeps every jmp bit in use while forcing word alignment.
      pc       <= jmp & ~ADDR_WIDTH'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_WIDTH'(4);
        inflight_pc <= pc;
      end
    end
  end

  // Output FIFO: entry 0 is the head; a redirect empties it (the head may
  // still have transferred that cycle, which needs no extra handling).
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
    end else if (jmp_enable) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            fifo_data[0] <= rd_data;
            fifo_pc[0]   <= inflight_pc;
          end else begin
            fifo_data[1] <= rd_data;
            fifo_pc[1]   <= inflight_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          fifo_data[0] <= fifo_data[1];
          fifo_pc[0]   <= fifo_pc[1];
          count        <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            fifo_data[0] <= rd_data;
            fifo_pc[0]   <= inflight_pc;
          end else begin
            fifo_data[0] <= fifo_data[1];
            fifo_pc[0]   <= fifo_pc[1];
            fifo_data[1] <= rd_data;
            fifo_pc[1]   <= inflight_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_tvalid    = (count != 2'd0);
  assign m_tdata     = fifo_data[0];
  assign m_tpc       = fifo_pc[0];
  assign ctrl_data_o = {fifo_data[0][31:25], fifo_data[0][14:12], fifo_data[0][6:0]};
  assign pc_o        = pc;
  assign halted_o    = pc_end && (count == 2'd0) && !inflight;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: expected beats are queued when
// the fetch stream is started and compared at every handshake.
module tb_instr_fetch_unit;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MD = 8;
  localparam int IW = 3;
  localparam logic [DW-1:0] NEW_WORD = 32'hFE0F_F0B3;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          jmp_enable;
  logic [AW-1:0] jmp;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [AW-1:0] m_tpc;
  logic [16:0]   ctrl_data_o;
  logic [AW-1:0] pc_o;
  logic          halted_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [AW+DW-1:0] sb [$];
  logic [DW-1:0]    shadow [MD];

  instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .jmp_enable(jmp_enable), .jmp(jmp), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tpc(m_tpc), .ctrl_data_o(ctrl_data_o), .pc_o(pc_o),
    .halted_o(halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ctrl_of(input logic [DW-1:0] d);
    return {d[31:25], d[14:12], d[6:0]};
  endfunction

  // Score any handshake seen in the current cycle, then advance one clock.
  task automatic step();
    logic [AW+DW-1:0] e;
    if (m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_beat", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("beat_pc", m_tpc, e[AW+DW-1:DW]);
        check("beat_data", m_tdata, e[DW-1:0]);
        check("beat_ctrl", ctrl_data_o, ctrl_of(e[DW-1:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_range(input int from_pc, input int to_pc);
    for (int p = from_pc; p <= to_pc; p += 4)
      sb.push_back({AW'(p), shadow[p/4]});
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int k = 0;
    while (sb.size() > 0 && k < max_cyc) begin
      step();
      k++;
    end
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic jump(input logic [AW-1:0] t);
    jmp_enable = 1'b1;
    jmp        = t;
    step();
    jmp_enable = 1'b0;
    jmp        = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, m_tvalid, 0);
    check({tag, "_tdata"}, m_tdata, 0);
    check({tag, "_tpc"}, m_tpc, 0);
    check({tag, "_ctrl"}, ctrl_data_o, 0);
    check({tag, "_pc"}, pc_o, 0);
    check({tag, "_halt"}, halted_o, 0);
  endtask

  initial begin
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_p;
    logic [AW-1:0] pc0;
    int k;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    jmp_enable = 1'b0; jmp = '0; m_tready = 1'b0;
    @(posedge clk);
    #1;

    // Program load while held in reset.
    for (int i = 0; i < MD; i++) begin
      wr_en   = 1'b1;
      wr_addr = IW'(i);
      wr_data = 32'h0000_0013 + 32'(i) * 32'h100;
      shadow[i] = wr_data;
      step();
    end
    wr_en = 1'b0;
    check_reset_vals("reset");

    // Streaming: first beat in cycle 2, one beat per cycle, halt after the last.
    m_tready = 1'b1;
    expect_range(0, 28);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check("strm_valid", m_tvalid, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) check("strm_pc", m_tpc, 64'(c - 2) * 4);
      check("strm_halt", halted_o, (c >= 10));
      step();
    end
    check("strm_sb_empty", sb.size(), 0);

    // Backpressure: hold m_tready low 5 cycles mid-stream.
    jump('0);
    expect_range(0, 28);
    k = 0;
    while (sb.size() > 5 && k < 12) begin step(); k++; end
    m_tready = 1'b0;
    check("bp_valid_start", m_tvalid, 1);
    hold_d = m_tdata;
    hold_p = m_tpc;
    pc0    = pc_o;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", m_tvalid, 1);
      check("bp_hold_data", m_tdata, hold_d);
      check("bp_hold_pc", m_tpc, hold_p);
    end
    check("bp_pc_advance", (pc_o - pc0) <= 8, 1);
    m_tready = 1'b1;
    drain("bp_drain", 30);
    check("bp_halt", halted_o, 1);

    // Redirect while the FIFO holds 0x8/0xC.
    jump('0);
    expect_range(0, 4);
    k = 0;
    while (sb.size() > 0 && k < 10) begin step(); k++; end
    m_tready = 1'b0;
    step();
    check("rd_pre_head", m_tpc, 16'h0008);
    check("rd_pre_valid", m_tvalid, 1);
    jump(16'h0010);
    check("rd_n1_valid", m_tvalid, 0);
    m_tready = 1'b1;
    expect_range(16, 28);
    step();
    check("rd_n2_valid", m_tvalid, 0);
    step();
    check("rd_n3_valid", m_tvalid, 1);
    check("rd_n3_pc", m_tpc, 16'h0010);
    drain("rd_drain", 20);

    // Misaligned target: low two bits ignored.
    jump(16'h0013);
    expect_range(16, 28);
    drain("mis_drain", 20);
    check("mis_halt", halted_o, 1);

    // Jump to program end halts next cycle; jump to 0 resumes.
    m_tready = 1'b0;
    jump('0);
    for (int i = 0; i < 4; i++) step();
    check("end_pre_valid", m_tvalid, 1);
    jump(16'(MD * 4));
    check("end_halt", halted_o, 1);
    check("end_valid", m_tvalid, 0);
    m_tready = 1'b1;
    jump('0);
    check("resume_unhalt", halted_o, 0);
    expect_range(0, 28);
    drain("resume_drain", 30);
    check("resume_halt", halted_o, 1);

    // Mid-stream reset with a full FIFO.
    m_tready = 1'b0;
    jump('0);
    for (int i = 0; i < 4; i++) step();
    check("mrst_pre_valid", m_tvalid, 1);
    rst = 1'b1;
    step();
    check_reset_vals("mrst");
    rst = 1'b0;
    m_tready = 1'b1;
    expect_range(0, 28);
    step();
    step();
    check("mrst_c2_valid", m_tvalid, 1);
    check("mrst_c2_pc", m_tpc, 0);
    drain("mrst_drain", 30);

    // Load index 3 in the same cycle PC 0xC issues: old word, then new after re-fetch.
    jump('0);
    expect_range(0, 28);
    k = 0;
    while (pc_o != 16'h000C && k < 10) begin step(); k++; end
    check("lwf_pc", pc_o, 16'h000C);
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = NEW_WORD;
    step();
    wr_en = 1'b0;
    shadow[3] = NEW_WORD;
    drain("lwf_old_drain", 30);
    jump(16'h000C);
    expect_range(12, 28);
    drain("lwf_new_drain", 30);
    check("lwf_halt", halted_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
